// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch address, handshakes with instruction memory and redirects on branch/exc/eret.
// Latency: every redirect or advance appears on pc one cycle after the triggering input; first request two cycles after reset.
// Backpressure: pc holds while stall is high or fetch_ready is low; redirects still act. Optional macro PC_SEQ_DELAY_SLOT_EN.

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module pc_sequencer #(
    parameter int             W            = `WORD_LEN,
    parameter logic [W-1:0]   RESET_VECTOR = W'(32'hBFC0_0000),
    parameter logic [W-1:0]   EXC_VECTOR   = W'(32'hBFC0_0380),
    parameter int             STEP         = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         fetch_ready,
    input  logic         br_taken,
    input  logic [W-1:0] br_target,
    input  logic         exc,
    input  logic         eret,
    output logic         fetch_valid,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_plus4,
    output logic [W-1:0] epc,
    output logic         bd,
    output logic [W-1:0] fetch_count
);

`ifdef PC_SEQ_DELAY_SLOT_EN
    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
`else
    typedef enum logic {BOOT, RUN} state_t;
`endif

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_pc;
    logic [W-1:0] w_pc_nxt;
    logic [W-1:0] r_epc;
    logic [W-1:0] w_epc_nxt;
    logic [W-1:0] r_fetch_count;
    logic [W-1:0] w_pc_step;
    logic         w_fire;

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic         r_bd;
    logic         w_bd_nxt;
    logic [W-1:0] r_pend_target;
    logic [W-1:0] w_pend_target_nxt;
`endif

    assign w_pc_step   = r_pc + W'(STEP);
    assign fetch_valid = (r_state != BOOT) & ~stall;
    assign w_fire      = fetch_valid & fetch_ready;

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_step;
    assign epc         = r_epc;
    assign fetch_count = r_fetch_count;
`ifdef PC_SEQ_DELAY_SLOT_EN
    assign bd          = r_bd;
`else
    assign bd          = 1'b0;
`endif

    // Next-state and next-PC selection: exc > eret > branch > fire > hold.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
`ifdef PC_SEQ_DELAY_SLOT_EN
        w_bd_nxt          = r_bd;
        w_pend_target_nxt = r_pend_target;
`endif
        case (r_state)
            BOOT: w_state_nxt = RUN;
            default: begin
                if (exc) begin
                    w_pc_nxt    = EXC_VECTOR;
                    w_epc_nxt   = r_pc;
                    w_state_nxt = RUN;
`ifdef PC_SEQ_DELAY_SLOT_EN
                    w_bd_nxt    = (r_state == PEND);
`endif
                end else if (eret) begin
                    w_pc_nxt    = r_epc;
                    w_state_nxt = RUN;
                end else if (br_taken) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
                    // Branch is deferred until the delay-slot instruction is accepted.
                    w_pend_target_nxt = br_target;
                    w_state_nxt       = PEND;
                    if (w_fire) begin
                        w_pc_nxt = w_pc_step;
                    end
`else
                    w_pc_nxt = br_target;
`endif
                end else if (w_fire) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
                    if (r_state == PEND) begin
                        w_pc_nxt    = r_pend_target;
                        w_state_nxt = RUN;
                    end else begin
                        w_pc_nxt = w_pc_step;
                    end
`else
                    w_pc_nxt = w_pc_step;
`endif
                end
            end
        endcase
    end

    // State, PC and exception registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    // Delay-slot bookkeeping: pending target and branch-delay flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bd          <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_bd          <= w_bd_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end
`endif

    // Accepted-fetch counter, counts every fire including ones coincident with a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_fire) begin
            r_fetch_count <= r_fetch_count + W'(1);
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer replacing the free-running `pc` + "add 4" arrangement at the front of the MIPS32 pipeline. It owns the fetch address, runs a valid/ready handshake with instruction memory, and redirects on taken branches, exceptions and `eret`. It also maintains EPC and a fetch counter. It sits between the decode/branch unit and instruction memory.

## Interface
- `W`, `` `WORD_LEN `` (32): address/data width.
- `RESET_VECTOR`, 32'hBFC0_0000: PC after reset.
- `EXC_VECTOR`, 32'hBFC0_0380: PC after exception.
- `STEP`, 4: sequential increment.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: hold current PC; suppresses `fetch_valid`.
- `fetch_ready` in 1: instruction memory accepts `pc` this cycle.
- `br_taken` in 1: one-cycle pulse, taken branch/jump.
- `br_target` in W: target address, valid with `br_taken`.
- `exc` in 1: exception pulse.
- `eret` in 1: exception-return pulse.
- `fetch_valid` out 1: `pc` is a fetch request.
- `pc` out W: current fetch address (registered).
- `pc_plus4` out W: `pc + STEP`, combinational.
- `epc` out W: saved exception PC.
- `bd` out 1: exception taken with a delay-slot branch pending.
- `fetch_count` out W: accepted fetches.

## Operation
- Fire: `fire = fetch_valid & fetch_ready`.
- `fetch_valid = (state != BOOT) & ~stall`.
- States:
  - BOOT: first cycle after reset release. Always goes to RUN.
  - RUN: normal sequencing.
  - PEND: delay-slot branch outstanding. Exists only with the macro.
- Next-PC priority, evaluated every cycle in RUN/PEND:
  1. `exc`: `pc <= EXC_VECTOR`; `epc <= pc`; `bd <= (state==PEND)`; pending cleared; state RUN.
  2. `eret`: `pc <= epc`; pending cleared; state RUN.
  3. `br_taken`: see Configuration.
  4. `fire`: `pc <= pc + STEP`. In PEND, `pc <= pend_target` instead and state goes to RUN.
  5. Otherwise: hold `pc`.
- Redirect rules:
  - `exc`, `eret` and the non-delay-slot branch act regardless of `stall` or `fire`.
  - The unaccepted request is abandoned. Memory samples `pc` only on fire, so `pc` may change while `fetch_valid` is high.
- `fetch_count` increments by 1 on every fire, including a fire in the same cycle as a redirect. It wraps at 2^W.
- All PC arithmetic is W-bit modulo. `pc_plus4` at 32'hFFFF_FFFC gives 0.
- Reset values:
  - `pc` = RESET_VECTOR; `pc_plus4` = RESET_VECTOR+STEP.
  - `fetch_valid` = 0; `epc` = 0; `bd` = 0; `fetch_count` = 0.
  - State BOOT; pending flag 0; `pend_target` = 0.
- Reset asserted mid-operation or mid-PEND returns everything to reset values immediately (asynchronous). Nothing pending survives.

## Timing
- Every redirect and advance is visible on `pc` the cycle after the triggering input.
- First fetch request: `fetch_valid` high in the second cycle after `rst` deasserts, provided `stall` is low.
- Sustained throughput: one fire per cycle while `fetch_ready=1` and `stall=0`.
- `epc` and `bd` update in the same edge as the exception redirect.
- `exc` and `eret` in the same cycle: `exc` wins; `epc` takes the current `pc`.

## Configuration
- Macro: `PC_SEQ_DELAY_SLOT_EN`.
- Defined (MIPS branch delay slot):
  - `br_taken` latches `pend_target <= br_target` and enters PEND. `pc` is unchanged by the branch itself; a coincident fire still advances `pc` to `pc+STEP`.
  - The next fire in PEND accepts the delay-slot instruction and loads `pc <= pend_target`.
  - `br_taken` while in PEND overwrites `pend_target` and stays in PEND.
  - `bd` is driven as described in Operation.
- Undefined:
  - `br_taken` loads `pc <= br_target` directly on the next edge.
  - PEND state, pending flag and `pend_target` are absent.
  - `bd` is tied to 0.

## Test plan
- Reset then run: release `rst`, `fetch_ready=1`, `stall=0`.
  - Cycle 1: `fetch_valid=0`, `pc`=BFC0_0000.
  - Then `pc` = BFC0_0000, BFC0_0004, BFC0_0008 on consecutive cycles; `fetch_count`=3 after three fires.
- Stall and backpressure: `stall=1` for 2 cycles, then `fetch_ready=0` for 2 cycles.
  - `pc` holds at the same value throughout; `fetch_valid` is 0 during stall and 1 during backpressure.
  - `fetch_count` unchanged.
- Branch without the macro: at `pc`=0x100 pulse `br_taken` with `br_target`=0x200. Next cycle `pc`=0x200.
- Branch with the macro: same stimulus. `pc` sequence is 0x100, 0x104, 0x200.
  - `exc` while in PEND: `pc`=BFC0_0380, `epc`=0x104, `bd`=1.
- Exception and return: `exc` at `pc`=0x40 gives `pc`=BFC0_0380 and `epc`=0x40.
  - A later `eret` gives `pc`=0x40.
  - `exc` and `eret` asserted together: `exc` wins.
- Wrap and async reset: force `pc`=FFFF_FFFC, then one fire gives `pc`=0.
  - Assert `rst` between clock edges: all outputs reach reset values before the next edge.
